chrono_controller: RTL and testbench

CHRONO_CONTROLLER -- requirements
Module: chrono_controller

---
 rtl/chrono_controller.sv | 182 ++++++++++++++++++
 tb/tb_chrono_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/chrono_controller.sv
// -----------------------------------------------------------------------------
// chrono_controller
//
// Stopwatch control FSM. Two raw push buttons are synchronized, debounced and
// turned into single-cycle press events. The events drive a four-state FSM
// that produces the control word for an external millisecond timer, and that
// captures lap times from that timer.
//
// Ports:
//   clock             single clock, all logic on its rising edge
//   reset_n           synchronous, active-low reset
//   btn_start_stop    raw asynchronous button, active-high
//   btn_lap_reset     raw asynchronous button, active-high
//   millisec_counter  live count from the millisecond timer
//   control_register  timer control: bit0 enable, bit1 reset, bits7:2 zero
//   lap_time          last captured lap value
//   lap_valid         one-cycle pulse in the first cycle a new lap_time shows
//   lap_frozen        high while the display should show lap_time
//   state             current FSM state (CLEAR=0, RUNNING=1, PAUSED=2, LAP=3)
//
// Output semantics: lap_valid is a qualifier-only strobe with no ready/back-
// pressure. It is high for exactly one cycle, in the same cycle that the new
// lap_time first appears, and the consumer must take the value then or rely
// on lap_time holding until the next capture or reset.
// -----------------------------------------------------------------------------
module chrono_controller #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int DEBOUNCE_MS     = 20
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        btn_start_stop,
    input  logic        btn_lap_reset,
    input  logic [31:0] millisec_counter,
    output logic [7:0]  control_register,
    output logic [31:0] lap_time,
    output logic        lap_valid,
    output logic        lap_frozen,
    output logic [1:0]  state
);

    localparam int DEBOUNCE_CYCLES_RAW = CLOCK_FREQUENCY / 1000 * DEBOUNCE_MS;
    // A zero-cycle debounce makes no sense; clamp so the counter stays legal.
    localparam int DEBOUNCE_CYCLES = (DEBOUNCE_CYCLES_RAW < 1) ? 1 : DEBOUNCE_CYCLES_RAW;
    // Wide enough to hold DEBOUNCE_CYCLES itself, not just DEBOUNCE_CYCLES-1.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_CLEAR   = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_LAP     = 2'd3;

    // Index 0 = start_stop, index 1 = lap_reset.
    logic [1:0] btn_raw;
    logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic [1:0] deb_level;
    logic [1:0] press;

    assign btn_raw = {btn_lap_reset, btn_start_stop};

    // Two-flop synchronizer; nothing downstream looks at the raw buttons.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_debounce
            logic [CNT_W-1:0] deb_cnt;
            logic             differ;
            logic             settle;

            assign differ = sync_b[g] ^ deb_level[g];
            // settle fires on the DEBOUNCE_CYCLES-th consecutive differing cycle.
            assign settle = differ && (deb_cnt == CNT_LAST);
            // Only a 0->1 settle is an event; the flip happens once per level
            // change, so a held button yields exactly one press.
            assign press[g] = settle && !deb_level[g];

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    deb_cnt      <= '0;
                    deb_level[g] <= 1'b0;
                end else if (!differ) begin
                    deb_cnt <= '0;
                end else if (settle) begin
                    deb_cnt      <= '0;
                    deb_level[g] <= ~deb_level[g];
                end else begin
                    deb_cnt <= deb_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    logic        ev_start_stop;
    logic        ev_lap_reset;
    logic [1:0]  state_q;
    logic [1:0]  state_next;
    logic        capture;
    logic [7:0]  ctrl_next;
    logic [7:0]  ctrl_q;
    logic [31:0] lap_time_q;
    logic        lap_valid_q;
    logic        lap_frozen_q;

    assign ev_start_stop = press[0];
    assign ev_lap_reset  = press[1];

    // start_stop is always tested first, so a simultaneous lap_reset event is
    // dropped rather than queued.
    always_comb begin
        state_next = state_q;
        capture    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (ev_start_stop) state_next = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (ev_start_stop) begin
                    state_next = ST_PAUSED;
                end else if (ev_lap_reset) begin
                    state_next = ST_LAP;
                    capture    = 1'b1;
                end
            end
            ST_LAP: begin
                if (ev_start_stop)     state_next = ST_PAUSED;
                else if (ev_lap_reset) state_next = ST_RUNNING;
            end
            ST_PAUSED: begin
                if (ev_start_stop)     state_next = ST_RUNNING;
                else if (ev_lap_reset) state_next = ST_CLEAR;
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state itself.
    always_comb begin
        ctrl_next = 8'h02;
        case (state_next)
            ST_CLEAR:   ctrl_next = 8'h02;
            ST_RUNNING: ctrl_next = 8'h01;
            ST_LAP:     ctrl_next = 8'h01;
            ST_PAUSED:  ctrl_next = 8'h00;
            default:    ctrl_next = 8'h02;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            ctrl_q       <= 8'h02;
            lap_time_q   <= 32'd0;
            lap_valid_q  <= 1'b0;
            lap_frozen_q <= 1'b0;
        end else begin
            state_q      <= state_next;
            ctrl_q       <= ctrl_next;
            lap_valid_q  <= capture;
            lap_frozen_q <= (state_next == ST_LAP);
            if (capture) lap_time_q <= millisec_counter;
        end
    end

    assign state            = state_q;
    assign control_register = ctrl_q;
    assign lap_time         = lap_time_q;
    assign lap_valid        = lap_valid_q;
    assign lap_frozen       = lap_frozen_q;

endmodule

// File: tb/tb_chrono_controller.sv
// -----------------------------------------------------------------------------
// tb_chrono_controller
//
// Directed bench for chrono_controller with DEBOUNCE_CYCLES = 4. Stimulus
// pushes the expected output tuple {state, control_register, lap_frozen,
// lap_valid, lap_time} for every visible output change; a monitor pops and
// compares whenever the observed tuple changes.
// -----------------------------------------------------------------------------
module tb_chrono_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_start_stop = 1'b0;
    logic        btn_lap_reset = 1'b0;
    logic [31:0] millisec_counter = 32'd0;
    logic [7:0]  control_register;
    logic [31:0] lap_time;
    logic        lap_valid;
    logic        lap_frozen;
    logic [1:0]  state;

    chrono_controller #(
        .CLOCK_FREQUENCY(1000),
        .DEBOUNCE_MS    (4)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .btn_start_stop  (btn_start_stop),
        .btn_lap_reset   (btn_lap_reset),
        .millisec_counter(millisec_counter),
        .control_register(control_register),
        .lap_time        (lap_time),
        .lap_valid       (lap_valid),
        .lap_frozen      (lap_frozen),
        .state           (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    localparam int TW = 44;
    logic [TW-1:0] exp_q[$];
    string         name_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          mon_en = 1'b0;
    logic [TW-1:0] prev_t;

    function automatic logic [TW-1:0] tup(input logic [1:0] s, input logic [7:0] c,
                                          input logic f, input logic v,
                                          input logic [31:0] t);
        return {s, c, f, v, t};
    endfunction

    task automatic expect_t(input string nm, input logic [1:0] s, input logic [7:0] c,
                            input logic f, input logic v, input logic [31:0] t);
        exp_q.push_back(tup(s, c, f, v, t));
        name_q.push_back(nm);
    endtask

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Monitor: any change of the observed tuple must match the head of the queue.
    always @(negedge clock) begin
        logic [TW-1:0] cur;
        logic [TW-1:0] e;
        string         nm;
        cur = {state, control_register, lap_frozen, lap_valid, lap_time};
        if (mon_en && cur !== prev_t) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change: got st=%0d ctrl=%h frz=%b vld=%b lap=%0d, want no change",
                         cur[43:42], cur[41:34], cur[33], cur[32], cur[31:0]);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (cur !== e) begin
                    n_err++;
                    $display("FAIL %s: got st=%0d ctrl=%h frz=%b vld=%b lap=%0d, want st=%0d ctrl=%h frz=%b vld=%b lap=%0d",
                             nm, cur[43:42], cur[41:34], cur[33], cur[32], cur[31:0],
                             e[43:42], e[41:34], e[33], e[32], e[31:0]);
                end
            end
            prev_t = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_drain(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) return;
            @(posedge clock);
        end
        n_vec++;
        n_err++;
        $display("FAIL %s_timeout: got %0d pending outputs, want 0", nm, exp_q.size());
        exp_q.delete();
        name_q.delete();
    endtask

    // mask bit0 = start_stop, bit1 = lap_reset; held 10 cycles then released.
    task automatic press(input string nm, input logic [1:0] mask);
        @(posedge clock); #1;
        btn_start_stop = mask[0];
        btn_lap_reset  = mask[1];
        repeat (10) @(posedge clock);
        #1;
        btn_start_stop = 1'b0;
        btn_lap_reset  = 1'b0;
        wait_drain(nm);
        repeat (12) @(posedge clock);
    endtask

    task automatic reset_pulse(input int cycles);
        @(posedge clock); #1;
        reset_n = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        prev_t = tup(2'd0, 8'h02, 1'b0, 1'b0, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        cmp("reset_state", 32'(state), 32'd0);
        cmp("reset_ctrl", 32'(control_register), 32'h02);
        cmp("reset_lap_time", lap_time, 32'd0);
        cmp("reset_lap_valid", 32'(lap_valid), 32'd0);
        cmp("reset_lap_frozen", 32'(lap_frozen), 32'd0);
        mon_en = 1'b1;

        // Idle: nothing may change.
        repeat (20) @(posedge clock);

        // 3-cycle glitch must not register.
        @(posedge clock); #1 btn_start_stop = 1'b1;
        repeat (3) @(posedge clock);
        #1 btn_start_stop = 1'b0;
        repeat (15) @(posedge clock);

        expect_t("clear_to_running", 2'd1, 8'h01, 1'b0, 1'b0, 32'd0);
        press("clear_to_running", 2'b01);

        millisec_counter = 32'd1234;
        expect_t("lap_capture", 2'd3, 8'h01, 1'b1, 1'b1, 32'd1234);
        expect_t("lap_valid_drop", 2'd3, 8'h01, 1'b1, 1'b0, 32'd1234);
        press("lap_capture", 2'b10);

        millisec_counter = 32'd2000;
        expect_t("lap_to_running", 2'd1, 8'h01, 1'b0, 1'b0, 32'd1234);
        press("lap_to_running", 2'b10);

        expect_t("running_to_paused", 2'd2, 8'h00, 1'b0, 1'b0, 32'd1234);
        press("running_to_paused", 2'b01);

        expect_t("paused_to_clear", 2'd0, 8'h02, 1'b0, 1'b0, 32'd1234);
        press("paused_to_clear", 2'b10);

        // lap_reset in CLEAR is ignored.
        millisec_counter = 32'd777;
        press("clear_lap_ignored", 2'b10);

        expect_t("clear_to_running2", 2'd1, 8'h01, 1'b0, 1'b0, 32'd1234);
        press("clear_to_running2", 2'b01);

        // Both buttons together: start_stop wins, no capture.
        millisec_counter = 32'd5678;
        expect_t("both_pressed", 2'd2, 8'h00, 1'b0, 1'b0, 32'd1234);
        press("both_pressed", 2'b11);

        expect_t("paused_to_running", 2'd1, 8'h01, 1'b0, 1'b0, 32'd1234);
        press("paused_to_running", 2'b01);

        millisec_counter = 32'd42;
        expect_t("lap_capture2", 2'd3, 8'h01, 1'b1, 1'b1, 32'd42);
        expect_t("lap_valid_drop2", 2'd3, 8'h01, 1'b1, 1'b0, 32'd42);
        press("lap_capture2", 2'b10);

        expect_t("lap_to_paused", 2'd2, 8'h00, 1'b0, 1'b0, 32'd42);
        press("lap_to_paused", 2'b01);

        expect_t("paused_to_running2", 2'd1, 8'h01, 1'b0, 1'b0, 32'd42);
        press("paused_to_running2", 2'b01);

        millisec_counter = 32'd99;
        expect_t("lap_capture3", 2'd3, 8'h01, 1'b1, 1'b1, 32'd99);
        expect_t("lap_valid_drop3", 2'd3, 8'h01, 1'b1, 1'b0, 32'd99);
        press("lap_capture3", 2'b10);

        // One-cycle reset while in LAP.
        expect_t("reset_in_lap", 2'd0, 8'h02, 1'b0, 1'b0, 32'd0);
        reset_pulse(1);
        wait_drain("reset_in_lap");
        repeat (10) @(posedge clock);

        expect_t("after_reset_run", 2'd1, 8'h01, 1'b0, 1'b0, 32'd0);
        press("after_reset_run", 2'b01);

        // Button held across reset release yields one press afterwards.
        expect_t("reset_held_btn", 2'd0, 8'h02, 1'b0, 1'b0, 32'd0);
        expect_t("held_btn_press", 2'd1, 8'h01, 1'b0, 1'b0, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        btn_start_stop = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (12) @(posedge clock);
        #1 btn_start_stop = 1'b0;
        wait_drain("held_btn_press");
        repeat (20) @(posedge clock);

        cmp("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
